cheat_engine_pipe: RTL and testbench
====================================

// Module: cheat_engine_pipe
// PURPOSE
// - Parametrised, pipelined successor of the arcade cheat engine.
// - Sits between the CPU read-data mux and the CPU; patches read data for addresses matching loaded codes.
// - Bus width is generic (8/16/32), with a registered 2-stage path for timing.
// - Adds XOR method, alignment rejection, overflow flag and a soft clear.
// PARAMETERS
// ADDR_WIDTH  16  byte-address width (<=32)
// DATA_WIDTH  16  read bus width: 8, 16 or 32; LANES=DATA_WIDTH/8, LB=$clog2(LANES)
// MAX_CODES   32  code slots; CW=$clog2(MAX_CODES+1)
// PORTS
// clk          in   1           clock
// reset        in   1           sync, active-high; empties table, clears pipeline/flags
// clear        in   1           soft clear: same effect on table/flags as reset (for new code set)
// enable       in   1           apply codes when 1 (sampled at stage 1)
// code         in   129         {strobe[128], flags[127:96], addr[95:64], compare[63:32], value[31:0]}
// code_ack     out  1           1-cycle pulse: code accepted into a slot
// code_rej     out  1           1-cycle pulse: code rejected (bad width/alignment or table full)
// overflow     out  1           sticky: a code arrived while table full
// code_count   out  CW          slots in use
// available    out  1           code_count != 0
// rd_valid_in  in   1           addr_in/data_in valid this cycle
// addr_in      in   ADDR_WIDTH  byte address of aligned bus word
// data_in      in   DATA_WIDTH  raw read data
// rd_valid_out out  1           data_out valid (rd_valid_in delayed 2)
// data_out     out  DATA_WIDTH  patched data
// hit          out  1           >=1 code modified this word (aligned with data_out)
// BEHAVIOUR
// Reset/clear
// - All outputs 0 except data_out, which is 0.
// - All slots invalid; in-flight stage-1 hit vector zeroed; strobe edge detector reset to 0.
// Loader
// - Acts on rising edge of code[128] (previous-sample register).
// - Flag fields: comp_f=code[96], width=code[102:100] (1/2/4 bytes), method=code[105:104].
// - Method 0=replace, 1=OR, 2=AND, 3=XOR.
// - Accept if width in {1,2,4}, width<=LANES, addr[log2(width)-1:0]==0 and code_count<MAX_CODES.
// - On accept, slot[code_count] receives lane mask, lane-shifted value/compare (lane=addr[LB-1:0]), addr, method, comp_f.
// - On accept, code_count++ and code_ack pulses the cycle after the edge.
// - Otherwise code_rej pulses; if the table is full, overflow is also set.
// - A new slot affects reads sampled from the cycle after code_ack onward. An unused slot never hits in flight.
// - Loading while clear=1: clear wins, code ignored.
// Pipeline (latency 2, throughput 1/cycle, no backpressure)
// - S1: hitvec[i] = enable & valid[i] & addr_in[AW-1:LB]==addr[i][AW-1:LB] & (!comp_f[i] | ((data_in^compare[i])&cmask[i])==0).
// - S1 registers hitvec, data_in and rd_valid_in.
// - S2: w=data; for i=0..MAX_CODES-1 ascending, if hitvec[i], each masked lane gets w=f(method,value,w).
// - Consequence: higher index wins for replace; OR/AND/XOR compose in order.
// - S2 registers data_out, hit=|hitvec and rd_valid_out.
// - Compare is evaluated on raw data_in, never on the output of another code.
// - When rd_valid_in=0: hitvec is forced to 0, and data passes through.
// - enable drops mid-stream: words already in S1 keep their hits.
// - clear mid-stream: S1 hits are zeroed; the next word out is unpatched.
// CONFIGURATION
// CHEAT_ENGINE_HIT_STATS_EN defined
// - Adds output hit_count[15:0]: counts cycles with rd_valid_out&hit.
// - Saturates at 16'hFFFF; zeroed by reset/clear.
// CHEAT_ENGINE_HIT_STATS_EN undefined
// - Port and counter absent; all else identical.
// TESTING
// - DW=16: load {w=1,m=0,addr=0x1001,val=0xAB}; read 0x1000 data 0x1234 -> 2 cycles later data_out=0xAB34, hit=1.
// - Same load, read 0x1002 data 0x1234 -> data_out=0x1234, hit=0.
// - comp_f=1, w=2, addr=0x20, cmp=0x0005, val=0x0009: data 0x0005 -> 0x0009; data 0x0006 -> 0x0006 unchanged.
// - Slot0 replace 0x10, slot1 XOR 0xFF, same byte, data 0x00 -> 0xEF.
// - Slot order reversed (XOR then replace) -> 0x10.
// - DW=16, w=4 code -> code_rej=1, count unchanged.
// - Fill MAX_CODES slots, then load one more -> code_rej=1, overflow=1, count=MAX_CODES.
// - Back-to-back reads every cycle with clear asserted at cycle 5 -> rd_valid_out continuous.
// - After clear: outputs pass through, count=0, available=0.
// - HIT_STATS_EN: 3 hitting reads + 2 misses -> hit_count=3.

Source files
------------

// File: rtl/cheat_engine_pipe.sv
// -----------------------------------------------------------------------------
// cheat_engine_pipe
//
// Patches CPU read data for addresses that match loaded cheat codes. It sits
// between the read-data mux and the CPU and adds two register stages.
//
// Optional feature: define CHEAT_ENGINE_HIT_STATS_EN to add the hit_count
// output, a saturating count of output words that were patched.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   clear          soft clear: empties the code table and clears the flags
//   enable         apply codes to reads (sampled in stage 1)
//   code           {strobe, flags[31:0], addr[31:0], compare[31:0], value[31:0]}
//   code_ack/rej   one-cycle pulses for an accepted or rejected code
//   overflow       sticky: a code arrived while the table was full
//   code_count     number of slots in use; available = code_count != 0
//   rd_valid_in, addr_in, data_in     raw read word
//   rd_valid_out, data_out, hit       patched word, two cycles later
//   hit_count      (optional) saturating count of patched output words
// -----------------------------------------------------------------------------
module cheat_engine_pipe #(
    parameter int  ADDR_WIDTH = 16,
    parameter int  DATA_WIDTH = 16,
    parameter int  MAX_CODES  = 32,
    localparam int LANES      = DATA_WIDTH / 8,
    localparam int CW         = $clog2(MAX_CODES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [128:0]          code,
    output logic                  code_ack,
    output logic                  code_rej,
    output logic                  overflow,
    output logic [CW-1:0]         code_count,
    output logic                  available,
    input  logic                  rd_valid_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rd_valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  hit
`ifdef CHEAT_ENGINE_HIT_STATS_EN
    ,
    output logic [15:0]           hit_count
`endif
);

    localparam int LB = (LANES > 1) ? $clog2(LANES) : 0;

    // Widen a per-byte lane mask into a per-bit mask.
    function automatic logic [DATA_WIDTH-1:0] lane_bits(input logic [LANES-1:0] m);
        logic [DATA_WIDTH-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = {8{m[l]}};
        return r;
    endfunction

    // ---------------- code table ----------------
    logic [LANES-1:0]      s_lmask  [MAX_CODES];
    logic [DATA_WIDTH-1:0] s_value  [MAX_CODES];
    logic [DATA_WIDTH-1:0] s_cmp    [MAX_CODES];
    logic [ADDR_WIDTH-1:0] s_addr   [MAX_CODES];
    logic [1:0]            s_method [MAX_CODES];
    logic                  s_comp   [MAX_CODES];

    // ---------------- loader decode ----------------
    logic                  strobe_q;
    logic                  strobe_edge;
    logic [2:0]            ld_width;
    logic [1:0]            ld_method;
    logic                  ld_comp;
    logic [31:0]           ld_addr;
    logic                  ld_fmt_ok;
    logic                  table_full;
    logic                  ld_accept;
    int                    ld_lane;
    logic [LANES-1:0]      ld_lmask;
    logic [DATA_WIDTH-1:0] ld_value;
    logic [DATA_WIDTH-1:0] ld_cmp;

    assign strobe_edge = code[128] & ~strobe_q;
    assign ld_width    = code[102:100];
    assign ld_method   = code[105:104];
    assign ld_comp     = code[96];
    assign ld_addr     = code[95:64];
    assign table_full  = (code_count == CW'(MAX_CODES));
    assign ld_accept   = strobe_edge & ld_fmt_ok & ~table_full & ~reset & ~clear;
    assign available   = (code_count != '0);

    // Flag bits without a function today, kept only so every code bit has a sink.
    logic unused_code_bits;
    assign unused_code_bits = ^{code[127:106], code[103], code[99:97], ld_addr};

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it holding its old value (which would infer a latch);
    // blocking '=' is right here because later lines read earlier results.
    always_comb begin
        ld_fmt_ok = 1'b0;
        ld_lane   = int'(ld_addr[1:0]) % LANES;
        ld_lmask  = '0;
        ld_value  = '0;
        ld_cmp    = '0;
        case (ld_width)
            3'd1:    ld_fmt_ok = 1'b1;
            3'd2:    ld_fmt_ok = (LANES >= 2) && !ld_addr[0];
            3'd4:    ld_fmt_ok = (LANES >= 4) && (ld_addr[1:0] == 2'b00);
            default: ld_fmt_ok = 1'b0;
        endcase
        // Place the value/compare bytes into the lanes the code covers.
        for (int l = 0; l < LANES; l++) begin
            if (l >= ld_lane && l < ld_lane + int'(ld_width)) begin
                ld_lmask[l]       = 1'b1;
                ld_value[l*8 +: 8] = code[(l - ld_lane)*8 +: 8];
                ld_cmp[l*8 +: 8]   = code[32 + (l - ld_lane)*8 +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            strobe_q   <= 1'b0;
            code_count <= '0;
            code_ack   <= 1'b0;
            code_rej   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            strobe_q <= code[128];
            code_ack <= 1'b0;
            code_rej <= 1'b0;
            if (strobe_edge) begin
                if (ld_accept) begin
                    code_count <= code_count + CW'(1);
                    code_ack   <= 1'b1;
                end else begin
                    code_rej <= 1'b1;
                    if (table_full) overflow <= 1'b1;
                end
            end
        end
    end

    // NOTE: slot contents are not reset; a slot is only consulted when its
    // index is below code_count, so clearing the count is enough.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_CODES; i++) begin
            if (ld_accept && CW'(i) == code_count) begin
                s_lmask[i]  <= ld_lmask;
                s_value[i]  <= ld_value;
                s_cmp[i]    <= ld_cmp;
                s_addr[i]   <= ld_addr[ADDR_WIDTH-1:0];
                s_method[i] <= ld_method;
                s_comp[i]   <= ld_comp;
            end
        end
    end

    // ---------------- stage 1: match ----------------
    logic [MAX_CODES-1:0]  hitvec;
    logic [MAX_CODES-1:0]  s1_hit;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    always_comb begin
        hitvec = '0;
        for (int i = 0; i < MAX_CODES; i++) begin
            hitvec[i] = enable && rd_valid_in && (i < int'(code_count))
                     && ((addr_in >> LB) == (s_addr[i] >> LB))
                     && (!s_comp[i]
                         || ((data_in ^ s_cmp[i]) & lane_bits(s_lmask[i])) == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_hit   <= '0;
        end else begin
            s1_valid <= rd_valid_in;
            s1_data  <= data_in;
            s1_hit   <= clear ? '0 : hitvec;
        end
    end

    // ---------------- stage 2: patch ----------------
    // The word sitting in stage 1 while clear is high loses its hits too.
    logic [MAX_CODES-1:0]  s1_eff;
    logic [DATA_WIDTH-1:0] s2_word;
    logic [DATA_WIDTH-1:0] s2_f;
    logic [DATA_WIDTH-1:0] s2_bm;

    assign s1_eff = clear ? '0 : s1_hit;

    // Ascending slot order: a later replace wins, OR/AND/XOR compose in order.
    always_comb begin
        s2_word = s1_data;
        s2_f    = '0;
        s2_bm   = '0;
        for (int i = 0; i < MAX_CODES; i++) begin
            if (s1_eff[i]) begin
                s2_bm = lane_bits(s_lmask[i]);
                case (s_method[i])
                    2'd0:    s2_f = s_value[i];
                    2'd1:    s2_f = s2_word | s_value[i];
                    2'd2:    s2_f = s2_word & s_value[i];
                    default: s2_f = s2_word ^ s_value[i];
                endcase
                s2_word = (s2_word & ~s2_bm) | (s2_f & s2_bm);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_out <= 1'b0;
            data_out     <= '0;
            hit          <= 1'b0;
        end else begin
            rd_valid_out <= s1_valid;
            data_out     <= s2_word;
            hit          <= |s1_eff;
        end
    end

`ifdef CHEAT_ENGINE_HIT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hit_count <= '0;
        end else if (rd_valid_out && hit && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cheat_engine_pipe.sv
// -----------------------------------------------------------------------------
// tb_cheat_engine_pipe
//
// Bench for cheat_engine_pipe with DATA_WIDTH=16, ADDR_WIDTH=16, MAX_CODES=32.
// Read vectors live in a table grouped by code set; expected words are queued
// when a read is driven and compared (value, hit and arrival cycle) when
// rd_valid_out shows up. Loader corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cheat_engine_pipe;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MC = 32;
    localparam int CW = $clog2(MC + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          enable;
    logic [128:0]  code;
    logic          code_ack, code_rej, overflow, available;
    logic [CW-1:0] code_count;
    logic          rd_valid_in;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          rd_valid_out;
    logic [DW-1:0] data_out;
    logic          hit;
`ifdef CHEAT_ENGINE_HIT_STATS_EN
    logic [15:0]   hit_count;
`endif

    cheat_engine_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CODES(MC)) dut (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .code(code),
        .code_ack(code_ack), .code_rej(code_rej), .overflow(overflow),
        .code_count(code_count), .available(available),
        .rd_valid_in(rd_valid_in), .addr_in(addr_in), .data_in(data_in),
        .rd_valid_out(rd_valid_out), .data_out(data_out), .hit(hit)
`ifdef CHEAT_ENGINE_HIT_STATS_EN
        , .hit_count(hit_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          hit;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (!reset) begin
            // An expected word whose cycle has passed never came out.
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("rd_valid_out_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (rd_valid_out) begin
                if (sb.size() == 0) begin
                    check("rd_valid_out_spurious", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_latency", cyc, e.cyc);
                    check("data_out", data_out, e.data);
                    check("hit", hit, e.hit);
                end
            end
        end
    end

    // ---------------- read vectors ----------------
    typedef struct {
        int            grp;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_data;
        logic          exp_hit;
    } vec_t;
    vec_t vecs[$];

    task automatic rd(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] ed, input logic eh);
        exp_t e;
        enable      = en;
        rd_valid_in = 1'b1;
        addr_in     = a;
        data_in     = d;
        e.data = ed;
        e.hit  = eh;
        e.cyc  = cyc + 2;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rd_valid_in = 1'b0;
        enable      = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_group(input int g);
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].grp == g)
                rd(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].exp_data, vecs[i].exp_hit);
        idle(4);
    endtask

    // ---------------- loader helpers ----------------
    task automatic load(input logic [2:0] w, input logic [1:0] m, input logic cf,
                        input logic [15:0] a, input logic [15:0] cmp, input logic [15:0] val,
                        input logic exp_ack, input string nm);
        code = {1'b1, 22'b0, m, 1'b0, w, 3'b0, cf, 16'b0, a, 16'b0, cmp, 16'b0, val};
        @(negedge clk);
        code[128] = 1'b0;
        check({nm, "_ack"}, code_ack, exp_ack);
        check({nm, "_rej"}, code_rej, !exp_ack);
        @(negedge clk);
        check({nm, "_pulse_end"}, {code_ack, code_rej}, 2'b00);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // grp 0: replace byte at 0x1001 with 0xAB
        vecs.push_back('{0, 1'b1, 16'h1000, 16'h1234, 16'hAB34, 1'b1});
        vecs.push_back('{0, 1'b1, 16'h1002, 16'h1234, 16'h1234, 1'b0});
        vecs.push_back('{0, 1'b1, 16'h1000, 16'hFFFF, 16'hABFF, 1'b1});
        vecs.push_back('{0, 1'b0, 16'h1000, 16'h1234, 16'h1234, 1'b0});
        vecs.push_back('{0, 1'b1, 16'h3000, 16'h5555, 16'h5555, 1'b0});
        vecs.push_back('{0, 1'b1, 16'h1000, 16'h0000, 16'hAB00, 1'b1});
        // grp 1: compare code, 16-bit word at 0x20, cmp 0x0005 -> 0x0009
        vecs.push_back('{1, 1'b1, 16'h0020, 16'h0005, 16'h0009, 1'b1});
        vecs.push_back('{1, 1'b1, 16'h0020, 16'h0006, 16'h0006, 1'b0});
        vecs.push_back('{1, 1'b1, 16'h0020, 16'h0105, 16'h0105, 1'b0});
        // grp 2: replace 0x10 then XOR 0xFF on the same byte
        vecs.push_back('{2, 1'b1, 16'h0040, 16'h0000, 16'h00EF, 1'b1});
        // grp 3: XOR then replace; AND 0x0F0F word then OR 0x80 high byte
        vecs.push_back('{3, 1'b1, 16'h0040, 16'h0000, 16'h0010, 1'b1});
        vecs.push_back('{3, 1'b1, 16'h0060, 16'h1234, 16'h8204, 1'b1});
        vecs.push_back('{3, 1'b1, 16'h0060, 16'hFFFF, 16'h8F0F, 1'b1});
        // grp 4: three hits and two misses with the 0x1001 code
        vecs.push_back('{4, 1'b1, 16'h1000, 16'h1111, 16'hAB11, 1'b1});
        vecs.push_back('{4, 1'b1, 16'h2000, 16'h1111, 16'h1111, 1'b0});
        vecs.push_back('{4, 1'b1, 16'h1000, 16'h2222, 16'hAB22, 1'b1});
        vecs.push_back('{4, 1'b1, 16'h1004, 16'h3333, 16'h3333, 1'b0});
        vecs.push_back('{4, 1'b1, 16'h1000, 16'h4444, 16'hAB44, 1'b1});

        reset = 1'b1; clear = 1'b0; enable = 1'b1; code = '0;
        rd_valid_in = 1'b0; addr_in = '0; data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_data_out", data_out, 16'h0);
        check("reset_flags", {rd_valid_out, hit, code_ack, code_rej, overflow, available},
              6'b0);
        check("reset_count", code_count, 0);

        // Basic replace
        load(3'd1, 2'd0, 1'b0, 16'h1001, 16'h0, 16'h00AB, 1'b1, "ld_a");
        check("count_after_a", code_count, 1);
        check("available_after_a", available, 1);
        run_group(0);

        // Compare code
        do_clear();
        load(3'd2, 2'd0, 1'b1, 16'h0020, 16'h0005, 16'h0009, 1'b1, "ld_cmp");
        run_group(1);

        // Method ordering
        do_clear();
        load(3'd1, 2'd0, 1'b0, 16'h0040, 16'h0, 16'h0010, 1'b1, "ld_rep");
        load(3'd1, 2'd3, 1'b0, 16'h0040, 16'h0, 16'h00FF, 1'b1, "ld_xor");
        run_group(2);
        do_clear();
        load(3'd1, 2'd3, 1'b0, 16'h0040, 16'h0, 16'h00FF, 1'b1, "ld_xor2");
        load(3'd1, 2'd0, 1'b0, 16'h0040, 16'h0, 16'h0010, 1'b1, "ld_rep2");
        load(3'd2, 2'd2, 1'b0, 16'h0060, 16'h0, 16'h0F0F, 1'b1, "ld_and");
        load(3'd1, 2'd1, 1'b0, 16'h0061, 16'h0, 16'h0080, 1'b1, "ld_or");
        run_group(3);

        // Format rejections leave the table untouched
        load(3'd4, 2'd0, 1'b0, 16'h0080, 16'h0, 16'h1234, 1'b0, "ld_w4");
        load(3'd2, 2'd0, 1'b0, 16'h0081, 16'h0, 16'h1234, 1'b0, "ld_misalign");
        load(3'd3, 2'd0, 1'b0, 16'h0080, 16'h0, 16'h1234, 1'b0, "ld_w3");
        check("count_after_rej", code_count, 4);
        check("no_overflow_on_fmt_rej", overflow, 0);

        // Fill the table, then overflow
        do_clear();
        for (int i = 0; i < MC; i++)
            load(3'd1, 2'd0, 1'b0, 16'(16'h4000 + 2 * i), 16'h0, 16'h0055, 1'b1, "ld_fill");
        check("count_full", code_count, MC);
        load(3'd1, 2'd0, 1'b0, 16'h5000, 16'h0, 16'h0055, 1'b0, "ld_over");
        check("overflow_set", overflow, 1);
        check("count_stays_full", code_count, MC);

        // Clear in the middle of a back-to-back stream
        do_clear();
        check("overflow_cleared", overflow, 0);
        load(3'd1, 2'd0, 1'b0, 16'h1001, 16'h0, 16'h00AB, 1'b1, "ld_stream");
        for (int i = 0; i < 10; i++) begin
            clear = (i == 5);
            rd(1'b1, 16'h1000, 16'h1234, (i < 4) ? 16'hAB34 : 16'h1234, i < 4);
        end
        clear = 1'b0;
        idle(4);
        check("count_after_clear", code_count, 0);
        check("available_after_clear", available, 0);
        rd(1'b1, 16'h1000, 16'h5678, 16'h5678, 1'b0);
        idle(4);

`ifdef CHEAT_ENGINE_HIT_STATS_EN
        do_clear();
        check("hit_count_cleared", hit_count, 0);
        load(3'd1, 2'd0, 1'b0, 16'h1001, 16'h0, 16'h00AB, 1'b1, "ld_stats");
        run_group(4);
        check("hit_count", hit_count, 3);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
